uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
Byte FIFO plus drain state machine sitting directly upstream of the UART transmitter. CPU/MMIO side pushes bytes at full clock rate. Block issues single-cycle tx_valid pulses toward the transmitter, one per frame, gated by the transmitter's tx_ready level. Decouples software from the 115200-baud line rate and gives software full, level and overflow status.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
ADDR_W, $clog2(DEPTH), pointer index width; derived, not overridden

Ports:
clk  in  1  system clock (27 MHz)
rst_n  in  1  reset
wr_en  in  1  push wr_data this cycle
wr_data  in  8  byte to enqueue
full  out  1  FIFO full; a push while high is dropped
empty  out  1  FIFO empty
level  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a push was dropped while full
ovf_clr  in  1  clears overflow
tx_data  out  8  byte to transmitter; stable from the tx_valid cycle until the next issue
tx_valid  out  1  one-cycle issue pulse to transmitter
tx_ready  in  1  transmitter idle level (high = idle; goes low the cycle after tx_valid)
busy  out  1  high when FIFO is non-empty or FSM is not in IDLE

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-low. Reset values: tx_valid=0, tx_data=0, overflow=0, pointers=0, level=0, empty=1, full=0, busy=0, state=IDLE.
- FIFO: circular buffer with ADDR_W+1-bit read/write pointers (extra wrap bit).
  - empty when the pointers are equal.
  - full when the indices are equal and the wrap bits differ.
  - level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - Status outputs are combinational from registered pointers.
- Push: wr_en && !full -> store the byte and increment wr_ptr.
- Dropped push: wr_en && full -> byte dropped, overflow<=1.
- Push when full with a same-cycle pop: the push is still dropped, because full is evaluated before the pop.
- Overflow set/clear: ovf_clr clears overflow. If ovf_clr and a dropped push happen in the same cycle, set wins.
- Simultaneous push and pop on a non-full FIFO: both take effect and level is unchanged.
- Drain FSM, states IDLE, ACK, DONE:
  - IDLE: if !empty && tx_ready, then tx_data<=head, tx_valid<=1, rd_ptr++, go to ACK.
  - ACK: tx_valid<=0. The transmitter drops tx_ready one cycle later. When tx_ready==0, go to DONE. Otherwise stay in ACK.
  - DONE: wait for tx_ready==1, then go to IDLE.
- Timing guarantees:
  - tx_valid is never high on two consecutive cycles.
  - tx_valid is never asserted outside IDLE.
  - Latency from a push into an empty FIFO (transmitter idle) to tx_valid high is 2 cycles: the write edge, then the IDLE decision edge.
  - Inter-byte gap is the transmitter frame plus at most 2 cycles.
- tx_ready low while in IDLE (transmitter busy from an earlier source): hold and do not pop.
- Reset mid-frame: all state clears asynchronously and queued bytes are lost. The transmitter shares rst_n.
- Wrap-around: pointers roll over naturally. DEPTH*2+3 consecutive bytes must transmit in order without loss when pushed at or below the drain rate.

Optional Feature:
- Macro: UART_TX_BUFFER_CRLF_EN.
- When defined: a head byte of 0x0A is sent as 0x0D followed by 0x0A.
  - In IDLE, if head==0x0A and the internal flag cr_sent==0: issue 0x0D without popping, set cr_sent.
  - The next issue sends 0x0A, pops it, and clears cr_sent.
  - cr_sent resets to 0.
  - busy also covers the pending LF.
- When undefined: bytes pass through unmodified. cr_sent logic is absent.

Decomposition:
- Package uart_pkg holds:
  - CLK_FREQ (27_000_000) and UART_BAUD (115200).
  - Drain FSM state encoding typedef (IDLE/ACK/DONE, 2 bits).
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- One sub-module, uart_sync_fifo, parameterised by DEPTH and width 8. It provides push/pop/head/full/empty/level.
- The drain FSM, overflow flag and CRLF logic stay in uart_tx_buffer.
- Bench instantiates uart_tx_buffer feeding the existing transmitter at 27 MHz / 115200.

Test Plan:
- Push 0x55 into an empty FIFO with tx_ready=1 -> tx_valid high for exactly 1 cycle, 2 cycles after the push, with tx_data=0x55; txd shows start bit, then 10101010 LSB-first, then stop; busy falls after the stop bit.
- Push 0x41,0x42,0x43 back-to-back -> three frames in order; no tx_valid while tx_ready=0; level goes 3→2→1→0.
- Push 17 bytes with DEPTH=16 while the transmitter is busy -> full=1 after 16; the 17th is dropped and overflow=1; ovf_clr pulse -> overflow=0; 16 bytes transmit.
- Push 35 bytes paced at one per frame -> all received in order, which proves pointer wrap.
- Assert rst_n=0 mid-frame with 5 bytes queued -> tx_valid=0, empty=1, level=0, overflow=0 immediately; no tx_valid after release until a new push.
- With UART_TX_BUFFER_CRLF_EN, push 0x48,0x0A -> line carries 0x48,0x0D,0x0A. Without the macro -> 0x48,0x0A.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared UART constants, ASCII codes and drain-FSM state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned CLK_FREQ  = 27_000_000;
  localparam int unsigned UART_BAUD = 115200;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_sync_fifo : single-clock circular FIFO with wrap-bit pointers
// Revision       : 1.0
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Extra wrap bit distinguishes full (indices equal, wraps differ) from empty.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                 (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;
  assign head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_buffer : byte FIFO + drain FSM issuing one tx_valid pulse per frame.
//                  Define UART_TX_BUFFER_CRLF_EN to expand LF into CR,LF.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  logic         w_push;
  logic         w_drop;
  logic         w_pop;
  logic         w_issue;
  logic         w_insert_cr;
  logic [7:0]   w_head;
  logic [7:0]   w_issue_byte;
  drain_state_t r_state;
  drain_state_t w_state_next;

  // Full is judged before any same-cycle pop, so a push at full is always lost.
  assign w_push = wr_en && !full;
  assign w_drop = wr_en && full;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .wr_data (wr_data),
    .pop     (w_pop),
    .head    (w_head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (w_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_BUFFER_CRLF_EN
  logic r_cr_sent;

  // An LF at the head is issued twice: first as CR (no pop), then as itself.
  assign w_insert_cr = (w_head == ASCII_LF) && !r_cr_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cr_sent <= 1'b0;
    end else if (w_issue) begin
      r_cr_sent <= w_insert_cr;
    end
  end

  assign busy = !empty || (r_state != IDLE) || r_cr_sent;
`else
  assign w_insert_cr = 1'b0;
  assign busy        = !empty || (r_state != IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_pop        = 1'b0;
    w_issue_byte = w_head;
    case (r_state)
      IDLE: begin
        if (!empty && tx_ready) begin
          w_issue      = 1'b1;
          w_pop        = !w_insert_cr;
          w_issue_byte = w_insert_cr ? ASCII_CR : w_head;
          w_state_next = ACK;
        end
      end
      ACK: begin
        if (!tx_ready) w_state_next = DONE;
      end
      DONE: begin
        if (tx_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_valid <= w_issue;
      if (w_issue) tx_data <= w_issue_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_buffer : directed bench with a compact transmitter model
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CPB   = 4;    // shortened bit period keeps the run small
  localparam int LIMIT = 400;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       hold    = 1'b0;
  logic       full, empty, overflow, tx_valid, tx_ready, busy, txd;
  logic [4:0] level;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int nvalid = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  // Transmitter model: accepts tx_valid when idle, drops ready the next cycle.
  logic       tx_busy;
  logic [9:0] sh;
  int         bitc, divc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      sh      <= '1;
      bitc    <= 0;
      divc    <= 0;
    end else if (!tx_busy) begin
      if (tx_valid) begin
        tx_busy <= 1'b1;
        sh      <= {1'b1, tx_data, 1'b0};
        bitc    <= 0;
        divc    <= 0;
      end
    end else if (divc == CPB - 1) begin
      divc <= 0;
      sh   <= {1'b1, sh[9:1]};
      bitc <= bitc + 1;
      if (bitc == 9) tx_busy <= 1'b0;
    end else begin
      divc <= divc + 1;
    end
  end

  assign txd      = tx_busy ? sh[0] : 1'b1;
  assign tx_ready = !tx_busy && !hold;

  always @(negedge clk) begin
    if (tx_valid && (prev_valid || !tx_ready)) viol <= viol + 1;
    if (tx_valid) nvalid <= nvalid + 1;
    prev_valid <= tx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic clr_ovf();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < LIMIT; n++) begin
      @(posedge clk);
      #1;
      if (tx_valid) break;
    end
    check(tag, tx_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < LIMIT && busy; n++) begin
      @(posedge clk);
      #1;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    logic [9:0] rx;
    logic [7:0] b;
    logic [7:0] crlf_exp [$];
    int         n0;

    rx = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data",  tx_data,  8'h00);
    check("rst_empty",    empty,    1'b1);
    check("rst_full",     full,     1'b0);
    check("rst_level",    level,    5'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy",     busy,     1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte: latency, one-cycle pulse, line frame, busy release
    push(8'h55);
    check("lat_write_edge", tx_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_issue_valid", tx_valid, 1'b1);
    check("lat_issue_data",  tx_data,  8'h55);
    @(posedge clk);
    #1;
    check("valid_one_cycle", tx_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      repeat (2) @(posedge clk);
      #1;
      rx[i] = txd;
      repeat (2) @(posedge clk);
    end
    check("frame_0x55", rx, 10'h2AA);
    #1;
    check("busy_during_stop", busy, 1'b1);
    @(posedge clk);
    #1;
    check("busy_after_stop", busy, 1'b0);

    // Three queued bytes drained in order while ready is honoured
    hold = 1'b1;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("abc_level3", level, 5'd3);
    repeat (5) @(posedge clk);
    #1;
    check("hold_no_pop", level, 5'd3);
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("abc_valid");
      check("abc_data",  tx_data, 32'(8'h41 + i));
      check("abc_level", level,   32'(2 - i));
    end
    wait_idle("abc_idle");

    // Fill, overflow, clear, set-wins, drop on same-cycle pop
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
    check("fill_full",     full,     1'b1);
    check("fill_level",    level,    5'd16);
    check("fill_no_ovf",   overflow, 1'b0);
    push(8'h90);
    check("ovf_set",       overflow, 1'b1);
    check("ovf_level",     level,    5'd16);
    clr_ovf();
    check("ovf_clear",     overflow, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'h91;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins",  overflow, 1'b1);
    clr_ovf();
    hold    = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    check("pop_push_drop_ovf", overflow, 1'b1);
    check("pop_push_level",    level,    5'd15);
    check("pop_push_valid",    tx_valid, 1'b1);
    check("pop_push_data",     tx_data,  8'h80);
    clr_ovf();
    for (int i = 1; i < DEPTH; i++) begin
      wait_valid("fill_valid");
      check("fill_data", tx_data, 32'(8'h80 + i));
    end
    wait_idle("fill_idle");
    check("fill_empty", empty, 1'b1);

    // Paced stream longer than two pointer wraps
    for (int i = 0; i < DEPTH * 2 + 3; i++) begin
      b = 8'(i * 37 + 1);
      push(b);
      wait_valid("wrap_valid");
      check("wrap_data", tx_data, b);
      wait_idle("wrap_idle");
    end

    // Asynchronous reset mid-frame with queued bytes
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
    repeat (10) @(posedge clk);
    #1;
    check("mid_level",    level,    5'd5);
    check("mid_tx_ready", tx_ready, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_empty",    empty,    1'b1);
    check("arst_level",    level,    5'd0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_busy",     busy,     1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = nvalid;
    repeat (60) @(posedge clk);
    #1;
    check("no_valid_after_rst", nvalid, n0);
    push(8'h5A);
    wait_valid("post_rst_valid");
    check("post_rst_data", tx_data, 8'h5A);
    wait_idle("post_rst_idle");

    // Line-ending handling
`ifdef UART_TX_BUFFER_CRLF_EN
    crlf_exp = '{8'h48, ASCII_CR, ASCII_LF};
`else
    crlf_exp = '{8'h48, ASCII_LF};
`endif
    hold = 1'b1;
    push(8'h48);
    push(ASCII_LF);
    hold = 1'b0;
    foreach (crlf_exp[i]) begin
      wait_valid("crlf_valid");
      check("crlf_data", tx_data, crlf_exp[i]);
    end
    wait_idle("crlf_idle");
    check("crlf_empty", empty, 1'b1);

    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
